// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and port indices for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr_pick.sv
// rtl/mem_port_arbiter_arb_rr_pick.sv - two-way round-robin choice; sel=1 picks the loader port
module arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic sel
);

  assign valid = req0 | req1;
  assign sel   = (req0 & req1) ? ~last_gnt : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/loader arbiter for the unified memory; ARB_STATS_EN adds grant/conflict counters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_conflict
`endif
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t        state, next_state;
  logic [CNT_W-1:0]  beat_cnt;
  logic              last_gnt;
  logic              pick_last, pick_valid, pick_sel;
  logic              at_limit, beat, rd0, rd1;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;

  // While a port holds the grant it counts as the most recent winner, so a
  // burst-limit switch always hands over to the other port.
  always_comb begin
    pick_last = last_gnt;
    if (state == GNT0) pick_last = PORT_CORE;
    if (state == GNT1) pick_last = PORT_LOAD;
  end

  arb_rr_pick u_pick (
    .req0     (p0_req),
    .req1     (p1_req),
    .last_gnt (pick_last),
    .valid    (pick_valid),
    .sel      (pick_sel)
  );

  assign at_limit = (beat_cnt == BEAT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (pick_valid) next_state = pick_sel ? GNT1 : GNT0;
      GNT0: if (!p0_req || (at_limit && p1_req))
              next_state = pick_valid ? (pick_sel ? GNT1 : GNT0) : IDLE;
      GNT1: if (!p1_req || (at_limit && p0_req))
              next_state = pick_valid ? (pick_sel ? GNT1 : GNT0) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    if (state == GNT0) begin
      mem_we    = p0_we & p0_req;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (state == GNT1) begin
      mem_we    = p1_we & p1_req;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  assign p0_gnt   = (state == GNT0);
  assign p1_gnt   = (state == GNT1);
  assign p0_stall = p0_req & ~p0_gnt;
  assign beat     = (p0_gnt & p0_req) | (p1_gnt & p1_req);
  assign rd0      = p0_gnt & p0_req & ~p0_we;
  assign rd1      = p1_gnt & p1_req & ~p1_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_gnt   <= PORT_LOAD;
      addr_hold  <= '0;
      wdata_hold <= '0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state      <= next_state;
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
      // Saturating at the limit lets a long solo hold yield as soon as contention starts.
      if (next_state != state)
        beat_cnt <= '0;
      else if (beat && !at_limit)
        beat_cnt <= beat_cnt + CNT_W'(1);
      if (p0_gnt) last_gnt <= PORT_CORE;
      if (p1_gnt) last_gnt <= PORT_LOAD;
      p0_rvalid <= rd0;
      p1_rvalid <= rd1;
      if (rd0) p0_rdata <= mem_rdata;
      if (rd1) p1_rdata <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (p0_gnt && p0_req && stat_gnt0 != 32'hFFFF_FFFF) stat_gnt0 <= stat_gnt0 + 32'd1;
      if (p1_gnt && p1_req && stat_gnt1 != 32'hFFFF_FFFF) stat_gnt1 <= stat_gnt1 + 32'd1;
      if (p0_req && p1_req && stat_conflict != 32'hFFFF_FFFF)
        stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_stall, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (mem_addr == 32'h10) mem_rdata = 32'hDEAD_BEEF;
    else                    mem_rdata = mem_addr ^ 32'hA5A5_0000;
  end

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_stall  (p0_stall),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_gnt0     (stat_gnt0),
    .stat_gnt1     (stat_gnt1),
    .stat_conflict (stat_conflict)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic e0;
    reset = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0;  p1_wdata = 32'h0;

    step(); step();
    check("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    check("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
    check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_p0_rdata", p0_rdata, 32'h0);

    reset = 1'b1;
    #1;
    check("rel_stall", {31'b0, p0_stall}, 32'd1);
    check("rel_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    step();
    check("rd_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    check("rd_stall_clr", {31'b0, p0_stall}, 32'd0);
    check("rd_mem_addr", mem_addr, 32'h10);
    check("rd_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    check("rd_rvalid", {31'b0, p0_rvalid}, 32'd1);
    check("rd_rdata", p0_rdata, 32'hDEAD_BEEF);
    p0_req = 1'b0;
    step();
    check("rd_rvalid_drop", {31'b0, p0_rvalid}, 32'd0);
    check("rd_gnt_drop", {31'b0, p0_gnt}, 32'd0);
    check("rd_rdata_hold", p0_rdata, 32'hDEAD_BEEF);
    check("idle_addr_hold", mem_addr, 32'h10);

    // Fresh reset so the tie-break starts from its reset value.
    reset = 1'b0;
    step();
    reset = 1'b1;
    p0_req = 1'b1; p0_addr = 32'h10;
    p1_req = 1'b1; p1_addr = 32'h30;
    step();
    for (int k = 0; k < 12; k++) begin
      e0 = (k < 4) || (k >= 8);
      check($sformatf("fair_p0_gnt_%0d", k), {31'b0, p0_gnt}, {31'b0, e0});
      check($sformatf("fair_p1_gnt_%0d", k), {31'b0, p1_gnt}, {31'b0, ~e0});
      check($sformatf("fair_stall_%0d", k), {31'b0, p0_stall}, {31'b0, ~e0});
      check($sformatf("fair_p0_rv_%0d", k), {31'b0, p0_rvalid},
            {31'b0, ((k >= 1 && k <= 4) || k >= 9)});
      check($sformatf("fair_p1_rv_%0d", k), {31'b0, p1_rvalid},
            {31'b0, (k >= 5 && k <= 8)});
      check($sformatf("fair_addr_%0d", k), mem_addr, e0 ? 32'h10 : 32'h30);
      if (k == 5) check("fair_p1_rdata", p1_rdata, 32'hA5A5_0030);
      if (k < 11) step();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    step();
    check("fair_end_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    check("fair_end_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    check("fair_end_rvalid", {31'b0, p0_rvalid}, 32'd0);

    p0_req = 1'b1;
    step();
    check("wr_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h55;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_blocked_we_%0d", k), {31'b0, mem_we}, 32'd0);
      check($sformatf("wr_blocked_gnt_%0d", k), {31'b0, p1_gnt}, 32'd0);
      if (k < 3) step();
    end
    step();
    check("wr_p1_gnt", {31'b0, p1_gnt}, 32'd1);
    check("wr_mem_we", {31'b0, mem_we}, 32'd1);
    check("wr_mem_addr", mem_addr, 32'h20);
    check("wr_mem_wdata", mem_wdata, 32'h55);
    check("wr_p0_stall", {31'b0, p0_stall}, 32'd1);
    step();
    p1_req = 1'b0; p1_we = 1'b0;
    #1;
    check("wr_tail_gnt", {31'b0, p1_gnt}, 32'd1);
    check("wr_tail_we", {31'b0, mem_we}, 32'd0);
    step();
    check("wr_back_p0", {31'b0, p0_gnt}, 32'd1);
    check("wr_back_we", {31'b0, mem_we}, 32'd0);
    p0_req = 1'b0;
    step();
    check("wr_idle_addr", mem_addr, 32'h10);

    p1_req = 1'b1; p1_addr = 32'h30;
    step();
    check("mid_beat1_gnt", {31'b0, p1_gnt}, 32'd1);
    step();
    check("mid_beat2_gnt", {31'b0, p1_gnt}, 32'd1);
    check("mid_beat2_rv", {31'b0, p1_rvalid}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_gnt", {31'b0, p1_gnt}, 32'd0);
    check("mid_rst_rv", {31'b0, p1_rvalid}, 32'd0);
    check("mid_rst_we", {31'b0, mem_we}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'h0);
`ifdef ARB_STATS_EN
    check("mid_rst_stat0", stat_gnt0, 32'h0);
    check("mid_rst_stat1", stat_gnt1, 32'h0);
    check("mid_rst_statc", stat_conflict, 32'h0);
`endif
    p0_req = 1'b1;
    step();
    check("mid_hold_gnt", {31'b0, p0_gnt | p1_gnt}, 32'd0);
    reset = 1'b1;
    step();
    check("mid_restart_p0", {31'b0, p0_gnt}, 32'd1);
    check("mid_restart_p1", {31'b0, p1_gnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
